averager: RTL and testbench
===========================

// Module: averager
// PURPOSE
//  Sliding-window mean and block peak detector for a 16-bit unsigned amplitude stream.
//  Sits after the envelope/magnitude stage and feeds the display/AGC logic.
//  A one-cycle 'next' strobe marks each new sample.
//  Outputs: the mean of the last 2**LOG2_N samples, and the peak of the last completed block.
// PARAMETERS
//  LOG2_N     4   window length N = 2**LOG2_N samples (N=16)
//  DATA_W     16  amplitude/average/max width, unsigned
//  BLOCK_LEN  16  samples per peak-detect block (1..65535)
// PORTS
//  clk        in   1       system clock; all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  amplitude  in   DATA_W  unsigned sample; valid on any cycle where next=1
//  next       in   1       sample strobe; each clk edge with next=1 consumes one sample
//  average    out  DATA_W  registered moving average of last N samples
//  max_val    out  DATA_W  registered peak of the last completed BLOCK_LEN samples
// BEHAVIOUR
//  Interface: one clock, clk. Reset rst is synchronous and active-high.
//  Reset (rst=1 at an edge):
//   - clears the N-entry sample buffer, write pointer, running sum, block counter and block peak
//   - average=0, max_val=0; reset has priority over next
//   - reset mid-stream discards all history; the window refills from zeros
//  Sample strobe: next is level-qualified. If next=1 for k consecutive cycles, k samples are taken.
//   - amplitude is read on the same edge; no backpressure, no ready signal
//  Window update (edge with next=1, rst=0):
//   - sum <= sum + amplitude - buf[wp]
//   - buf[wp] <= amplitude
//   - wp <= wp+1 mod N (natural wrap)
//  Arithmetic:
//   - sum is DATA_W+LOG2_N bits unsigned and can never overflow
//   - average <= (new sum) >> LOG2_N, truncating
//   - average is valid the cycle after the strobe (latency 1)
//  Startup: buffer starts at zero, so average ramps as amount/N until N samples have been taken.
//  Peak: blk_max tracks the max of the samples in the current block.
//   - on the BLOCK_LEN-th sample: max_val <= max(blk_max, amplitude); blk_max <= 0; count <= 0
//   - otherwise: blk_max <= max(blk_max, amplitude)
//   - max_val updates only at block end (latency 1); it holds between blocks
//  Equal values: >= compare, so an equal sample keeps the same value.
//  No strobe: all state and both outputs hold indefinitely.
//  Boundary cases:
//   - amplitude=16'hFFFF for N samples gives average=16'hFFFF
//   - window wrap and block wrap on the same edge are independent and both apply
// STRUCTURE
//  Shared package averager_pkg: DATA_W, LOG2_N defaults and the sum-width localparam SUM_W=DATA_W+LOG2_N.
//  Sub-module avg_delay_line: N x DATA_W register ring buffer.
//   - ports: clk, rst, we, din, dout_oldest
//   - synchronous clear on rst
//  The parent holds the accumulator, shift/divide, and the block peak logic with its counter.
// TESTING
//  1 Reset: hold rst 10 cycles with next toggling -> average=0, max_val=0 throughout.
//  2 Ramp: after reset, one sample 1600 -> average=100 next cycle; 16 samples of 1000 -> average=1000.
//  3 Mixed window: samples 1080, 1900x6, 1960x6 repeated.
//    - steady state: average = floor(sum of last 16 / 16), checked against a model
//    - max_val=1960 after the first full block
//  4 Level drop: stream 190/196 after 1900/1960 -> average decays to the low level within 16 samples.
//    - max_val holds until the block completes, then becomes 196
//  5 Saturation: 16 samples of 65535 -> average=65535, max_val=65535, no wrap.
//  6 Back-to-back strobes: next=1 for 16 consecutive cycles at 500 -> average=500.
//    - mid-stream rst returns both outputs to 0 on the next edge

Source files
------------

// File: rtl/averager_pkg.sv
// Shared widths for the averager slice: default sample/window sizes and derived accumulator width.
package averager_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LOG2_N = 4;
  localparam int unsigned SUM_W  = DATA_W + LOG2_N;
  localparam int unsigned CNT_W  = 16;

endpackage

// File: rtl/avg_delay_line.sv
// Ring buffer of the last 2**DEPTH_LOG2 samples; dout_oldest is the entry about to be overwritten.
module avg_delay_line #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_oldest
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
    end else if (we) begin
      mem_q[wp_q] <= din;
      wp_q        <= wp_q + DEPTH_LOG2'(1);
    end
  end

  assign dout_oldest = mem_q[wp_q];

endmodule

// File: rtl/averager.sv
// Sliding-window mean over the last 2**LOG2_N strobed samples plus per-block peak detector.
module averager
  import averager_pkg::*;
#(
  parameter int unsigned LOG2_N    = averager_pkg::LOG2_N,
  parameter int unsigned DATA_W    = averager_pkg::DATA_W,
  parameter int unsigned BLOCK_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] amplitude,
  input  logic              next,
  output logic [DATA_W-1:0] average,
  output logic [DATA_W-1:0] max_val
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  logic [DATA_W-1:0] oldest;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] avg_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] blk_max_q, blk_max_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              blk_end;

  avg_delay_line #(
    .DEPTH_LOG2 (LOG2_N),
    .WIDTH      (DATA_W)
  ) u_delay (
    .clk         (clk),
    .rst         (rst),
    .we          (next),
    .din         (amplitude),
    .dout_oldest (oldest)
  );

  // The sum always contains the oldest sample, so the subtraction never underflows.
  always_comb begin
    sum_d     = sum_q + ACC_W'(amplitude) - ACC_W'(oldest);
    blk_max_d = (amplitude >= blk_max_q) ? amplitude : blk_max_q;
    blk_end   = (cnt_q == CNT_W'(BLOCK_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      avg_q     <= '0;
      max_q     <= '0;
      blk_max_q <= '0;
      cnt_q     <= '0;
    end else if (next) begin
      sum_q <= sum_d;
      avg_q <= sum_d[ACC_W-1:LOG2_N];
      if (blk_end) begin
        max_q     <= blk_max_d;
        blk_max_q <= '0;
        cnt_q     <= '0;
      end else begin
        blk_max_q <= blk_max_d;
        cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign average = avg_q;
  assign max_val = max_q;

endmodule

// File: tb/tb_averager.sv
// Directed bench for averager: hand-computed checkpoints plus a window/block reference model.
module tb_averager;

  logic        clk;
  logic        rst;
  logic [15:0] amplitude;
  logic        next;
  logic [15:0] average;
  logic [15:0] max_val;

  int total = 0;
  int bad   = 0;

  int unsigned win[$];
  logic [15:0] m_avg;
  logic [15:0] m_max;
  logic [15:0] m_blk;
  int          m_cnt;

  averager #(
    .LOG2_N    (4),
    .DATA_W    (16),
    .BLOCK_LEN (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .amplitude (amplitude),
    .next      (next),
    .average   (average),
    .max_val   (max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_avg = '0;
    m_max = '0;
    m_blk = '0;
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [15:0] a);
    int unsigned s;
    win.push_back(int'(a));
    if (win.size() > 16) void'(win.pop_front());
    s = 0;
    foreach (win[k]) s += win[k];
    m_avg = 16'(s / 16);
    if (a >= m_blk) m_blk = a;
    m_cnt++;
    if (m_cnt == 16) begin
      m_max = m_blk;
      m_blk = '0;
      m_cnt = 0;
    end
  endtask

  // Back-to-back calls keep next high across consecutive edges.
  task automatic push(input logic [15:0] a);
    amplitude = a;
    next      = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    model_push(a);
    chk("win_avg", average, m_avg);
    chk("blk_max", max_val, m_max);
  endtask

  initial begin
    rst       = 1'b1;
    next      = 1'b0;
    amplitude = '0;
    model_reset();
    #3;

    for (int i = 0; i < 10; i++) begin
      next      = i[0];
      amplitude = 16'(1234 + i);
      @(posedge clk);
      #1;
      chk("rst_avg", average, 16'd0);
      chk("rst_max", max_val, 16'd0);
    end
    rst  = 1'b0;
    next = 1'b0;

    push(16'd1600);
    chk("ramp_first", average, 16'd100);
    repeat (16) push(16'd1000);
    chk("ramp_full_avg", average, 16'd1000);
    chk("ramp_block_max", max_val, 16'd1600);

    for (int r = 0; r < 3; r++) begin
      push(16'd1080);
      repeat (6) push(16'd1900);
      repeat (6) push(16'd1960);
    end
    chk("mixed_max", max_val, 16'd1960);

    for (int i = 0; i < 24; i++) begin
      push(i[0] ? 16'd196 : 16'd190);
      if (i == 6) chk("drop_hold_max", max_val, 16'd1960);
      if (i == 15) chk("drop_avg16", average, 16'd193);
    end
    chk("drop_avg", average, 16'd193);
    chk("drop_max", max_val, 16'd196);

    repeat (16) push(16'hFFFF);
    chk("sat_avg", average, 16'hFFFF);
    chk("sat_max", max_val, 16'hFFFF);

    next = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_avg", average, 16'hFFFF);
    chk("idle_max", max_val, 16'hFFFF);

    repeat (16) push(16'd500);
    chk("b2b_avg", average, 16'd500);
    chk("b2b_max", max_val, 16'd500);

    push(16'd700);
    push(16'd800);
    amplitude = 16'd999;
    next      = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_avg", average, 16'd0);
    chk("midrst_max", max_val, 16'd0);
    rst  = 1'b0;
    next = 1'b0;
    model_reset();

    push(16'd1600);
    chk("refill_avg", average, 16'd100);
    chk("refill_max", max_val, 16'd0);
    repeat (14) push(16'd320);
    chk("refill_blk_pending", max_val, 16'd0);
    push(16'd320);
    chk("refill_blk_done", max_val, 16'd1600);
    chk("refill_avg_full", average, 16'd400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
